// File: rtl/crc16_tx_arb_pkg.sv
// Shared types and constants for the two-channel CRC16 transmit arbiter.
// The CRC is CCITT (x^16+x^12+x^5+1), MSB-first, with no reflection and no final XOR.
package crc16_tx_arb_pkg;

  localparam logic [15:0] CRC_POLY     = 16'h1021;
  localparam logic [15:0] CRC_INIT_DEF = 16'hFFFF;
  localparam int          NUM_CH       = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_CRC,
    ST_DROP
  } state_e;

  typedef struct packed {
    logic [15:0] data;
    logic        sop;
    logic        eop;
  } word_t;

endpackage

// File: rtl/crc16_tx_arb_if.sv
// Handshake bundle for the arbiter: two source channels, one output stream, and status.
// The slave modport is the arbiter side; the master modport is the environment side.
interface crc16_tx_arb_if;
  logic [15:0] s0_data;
  logic        s0_vld;
  logic        s0_eop;
  logic        s0_rdy;
  logic [15:0] s1_data;
  logic        s1_vld;
  logic        s1_eop;
  logic        s1_rdy;
  logic [15:0] m_data;
  logic        m_vld;
  logic        m_sop;
  logic        m_eop;
  logic        m_rdy;
  logic        grant_ch;
  logic        busy;
  logic        len_err;

  modport slave (
    input  s0_data, s0_vld, s0_eop, s1_data, s1_vld, s1_eop, m_rdy,
    output s0_rdy, s1_rdy, m_data, m_vld, m_sop, m_eop, grant_ch, busy, len_err
  );

  modport master (
    output s0_data, s0_vld, s0_eop, s1_data, s1_vld, s1_eop, m_rdy,
    input  s0_rdy, s1_rdy, m_data, m_vld, m_sop, m_eop, grant_ch, busy, len_err
  );
endinterface

// File: rtl/crc16_d16_next.sv
// Combinational CRC16 step over one 16-bit word: next(c,d) = F(c ^ d).
// F applies 16 zero-input shifts of the CCITT LFSR.
module crc16_d16_next
  import crc16_tx_arb_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [15:0] din,
  output logic [15:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ din;
    for (int i = 0; i < 16; i++)
      crc_out = crc_out[15] ? ((crc_out << 1) ^ CRC_POLY) : (crc_out << 1);
  end

endmodule

// File: rtl/crc16_tx_arb.sv
// Round-robin frame arbiter that shares one CRC16 engine between two sources.
// Data passes through combinationally, the CRC word is appended, and frames longer than MAX_WORDS are truncated.
module crc16_tx_arb
  import crc16_tx_arb_pkg::*;
#(
  parameter int          MAX_WORDS = 1024,
  parameter logic [15:0] CRC_INIT  = CRC_INIT_DEF
) (
  input  logic           clk_sys,
  input  logic           rst_sys,
  crc16_tx_arb_if.slave  bus
);

  localparam int                 CNT_W    = $clog2(MAX_WORDS);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MAX_WORDS - 1);

  state_e                        state;
  logic [15:0]                   crc_reg;
  logic [15:0]                   crc_nxt;
  logic [CNT_W-1:0]              word_cnt;
  logic                          grant_ch;
  logic                          last_ch;
  logic                          trunc;
  logic                          len_err;

  logic [NUM_CH-1:0][15:0]       s_data;
  logic [NUM_CH-1:0]             s_vld;
  logic [NUM_CH-1:0]             s_eop;
  logic [NUM_CH-1:0]             s_rdy;
  logic [15:0]                   sel_data;
  logic                          sel_vld;
  logic                          sel_eop;
  logic                          sel_hs;
  word_t                         m_word;
  logic                          m_vld;

  assign s_data   = {bus.s1_data, bus.s0_data};
  assign s_vld    = {bus.s1_vld,  bus.s0_vld};
  assign s_eop    = {bus.s1_eop,  bus.s0_eop};
  assign sel_data = s_data[grant_ch];
  assign sel_vld  = s_vld[grant_ch];
  assign sel_eop  = s_eop[grant_ch];
  assign sel_hs   = sel_vld & s_rdy[grant_ch];

  crc16_d16_next u_crc (
    .crc_in  (crc_reg),
    .din     (sel_data),
    .crc_out (crc_nxt)
  );

  always_comb begin
    s_rdy  = '0;
    m_word = '0;
    m_vld  = 1'b0;
    case (state)
      ST_DATA: begin
        m_word.data     = sel_data;
        m_word.sop      = (word_cnt == '0);
        m_vld           = sel_vld;
        s_rdy[grant_ch] = bus.m_rdy;
      end
      ST_CRC: begin
        m_word.data = crc_reg;
        m_word.eop  = 1'b1;
        m_vld       = 1'b1;
      end
      ST_DROP: s_rdy[grant_ch] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state    <= ST_IDLE;
      crc_reg  <= CRC_INIT;
      word_cnt <= '0;
      grant_ch <= 1'b0;
      last_ch  <= 1'b1;
      trunc    <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        ST_IDLE: if (|s_vld) begin
          // When both channels request, the one not served last wins.
          grant_ch <= (&s_vld) ? ~last_ch : s_vld[1];
          crc_reg  <= CRC_INIT;
          word_cnt <= '0;
          state    <= ST_DATA;
        end
        ST_DATA: if (sel_hs) begin
          crc_reg <= crc_nxt;
          if (word_cnt != CNT_LAST) word_cnt <= word_cnt + 1'b1;
          if (sel_eop) begin
            state <= ST_CRC;
          end else if (word_cnt == CNT_LAST) begin
            state   <= ST_CRC;
            trunc   <= 1'b1;
            len_err <= 1'b1;
          end
        end
        ST_CRC: if (bus.m_rdy) begin
          last_ch <= grant_ch;
          state   <= trunc ? ST_DROP : ST_IDLE;
        end
        ST_DROP: if (sel_hs && sel_eop) begin
          trunc <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.s0_rdy   = s_rdy[0];
  assign bus.s1_rdy   = s_rdy[1];
  assign bus.m_data   = m_word.data;
  assign bus.m_sop    = m_word.sop;
  assign bus.m_eop    = m_word.eop;
  assign bus.m_vld    = m_vld;
  assign bus.grant_ch = grant_ch;
  assign bus.busy     = (state != ST_IDLE);
  assign bus.len_err  = len_err;

endmodule

// File: tb/tb_crc16_tx_arb.sv
// Scoreboard bench for crc16_tx_arb: stimulus pushes expected output words, and a monitor pops and compares them.
// MAX_WORDS=5 lets one instance cover both the exact-limit frame and truncation.
module tb_crc16_tx_arb;
  import crc16_tx_arb_pkg::*;

  localparam int MAXW = 5;

  typedef struct {
    word_t w;
    logic  ch;
  } exp_t;

  logic clk_sys = 1'b0;
  logic rst_sys = 1'b1;
  crc16_tx_arb_if bus ();

  crc16_tx_arb #(.MAX_WORDS(MAXW), .CRC_INIT(16'hFFFF)) dut (
    .clk_sys (clk_sys),
    .rst_sys (rst_sys),
    .bus     (bus)
  );

  always #4 clk_sys = ~clk_sys;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   len_err_cnt = 0;
  int   last_eop_cyc = -1;
  bit   bp_en = 1'b0;
  bit   gap_chk = 1'b0;
  bit   expect_drop = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bit-serial reference CRC, written independently of the parallel RTL form.
  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [15:0] d);
    logic fb;
    for (int i = 15; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  function automatic logic [15:0] frame_crc(input logic [15:0] w[$]);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < w.size() && i < MAXW; i++) c = crc_model(c, w[i]);
    return c;
  endfunction

  task automatic push_frame(input bit ch, input logic [15:0] w[$], input logic [15:0] crc);
    exp_t e;
    for (int i = 0; i < w.size() && i < MAXW; i++) begin
      e.w = '{data: w[i], sop: (i == 0), eop: 1'b0};
      e.ch = ch;
      sb.push_back(e);
    end
    e.w = '{data: crc, sop: 1'b0, eop: 1'b1};
    e.ch = ch;
    sb.push_back(e);
  endtask

  task automatic drive(input bit ch, input logic v, input logic [15:0] d, input logic eop);
    if (ch) begin bus.s1_vld = v; bus.s1_data = d; bus.s1_eop = eop; end
    else    begin bus.s0_vld = v; bus.s0_data = d; bus.s0_eop = eop; end
  endtask

  function automatic logic rdy_of(input bit ch);
    return ch ? bus.s1_rdy : bus.s0_rdy;
  endfunction

  task automatic send_frame(input bit ch, input logic [15:0] w[$]);
    int t;
    for (int i = 0; i < w.size(); i++) begin
      drive(ch, 1'b1, w[i], i == w.size() - 1);
      t = 0;
      forever begin
        @(negedge clk_sys);
        if (rdy_of(ch)) break;
        if (++t > 300) break;
      end
      if (t > 300) begin
        chk("src_timeout", 32'(ch), 32'hDEAD);
        drive(ch, 1'b0, 16'h0, 1'b0);
        return;
      end
      @(posedge clk_sys); #1;
    end
    drive(ch, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic do_reset();
    rst_sys = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1 rst_sys = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin @(posedge clk_sys); t++; end
    chk("drain", 32'(sb.size()), 0);
    repeat (2) @(posedge clk_sys);
    #1;
  endtask

  // Only driver of m_rdy; random when backpressure is enabled.
  initial begin
    bus.m_rdy = 1'b1;
    forever begin
      @(posedge clk_sys); #1;
      bus.m_rdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor
  initial begin
    exp_t  e;
    bit    prev_stall = 1'b0;
    word_t prev_word = '0;
    bit    busy_pend = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (rst_sys) begin prev_stall = 1'b0; busy_pend = 1'b0; continue; end
      if (bus.len_err) len_err_cnt++;
      if (busy_pend) begin chk("busy_after_crc", 32'(bus.busy), 0); busy_pend = 1'b0; end
      if (prev_stall) begin
        chk("hold_vld", 32'(bus.m_vld), 1);
        chk("hold_word", 32'({bus.m_data, bus.m_sop, bus.m_eop}), 32'(prev_word));
      end
      if (bus.m_vld && bus.m_rdy) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 32'(bus.m_data), 32'h0001_0000);
        end else begin
          e = sb.pop_front();
          chk("out_word", 32'({bus.m_data, bus.m_sop, bus.m_eop}), 32'(e.w));
          if (bus.m_sop) begin
            chk("grant_ch", 32'(bus.grant_ch), 32'(e.ch));
            if (gap_chk && last_eop_cyc >= 0) chk("frame_gap", 32'(cyc - last_eop_cyc), 2);
          end
          if (bus.m_eop) begin
            last_eop_cyc = cyc;
            if (!expect_drop) busy_pend = 1'b1;
          end
        end
      end
      prev_stall = bus.m_vld && !bus.m_rdy;
      prev_word  = '{data: bus.m_data, sop: bus.m_sop, eop: bus.m_eop};
    end
  end

  initial begin
    logic [15:0] w0[$];
    logic [15:0] w1[$];
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    do_reset();
    @(negedge clk_sys);
    chk("reset_outputs", 32'({bus.m_vld, bus.m_sop, bus.m_eop, bus.s0_rdy, bus.s1_rdy,
                              bus.grant_ch, bus.busy, bus.len_err, bus.m_data}), 0);
    @(posedge clk_sys); #1;

    // Single-word frame on ch0
    w0 = {}; w0.push_back(16'h0000);
    push_frame(1'b0, w0, 16'h1D0F);
    send_frame(1'b0, w0);
    wait_drain();

    // ch1: a two-word frame, then a single-word 0xFFFF frame
    w1 = {}; w1.push_back(16'h0000); w1.push_back(16'h0000);
    push_frame(1'b1, w1, 16'h84C0);
    send_frame(1'b1, w1);
    w1 = {}; w1.push_back(16'hFFFF);
    push_frame(1'b1, w1, 16'h0000);
    send_frame(1'b1, w1);
    wait_drain();

    // Both channels request continuously, so grants must alternate starting with ch0.
    do_reset();
    w0 = {}; w0.push_back(16'h0000);
    for (int i = 0; i < 4; i++) push_frame(1'(i % 2), w0, 16'h1D0F);
    gap_chk = 1'b1; last_eop_cyc = -1;
    fork
      begin send_frame(1'b0, w0); send_frame(1'b0, w0); end
      begin send_frame(1'b1, w0); send_frame(1'b1, w0); end
    join
    wait_drain();
    gap_chk = 1'b0;

    // Backpressure on a five-word frame, which ends exactly at MAX_WORDS and must not truncate.
    len_err_cnt = 0;
    w0 = {}; w0.push_back(16'h1234); w0.push_back(16'hABCD); w0.push_back(16'h0F0F);
    w0.push_back(16'h8001); w0.push_back(16'hFFFF);
    push_frame(1'b0, w0, frame_crc(w0));
    bp_en = 1'b1;
    send_frame(1'b0, w0);
    wait_drain();
    bp_en = 1'b0;
    chk("len_err_at_limit", 32'(len_err_cnt), 0);

    // Seven words on ch0: five words plus CRC go out, and words 6-7 are dropped.
    len_err_cnt = 0;
    expect_drop = 1'b1;
    w0 = {};
    for (int i = 1; i <= 7; i++) w0.push_back(16'(i));
    push_frame(1'b0, w0, frame_crc(w0));
    send_frame(1'b0, w0);
    @(negedge clk_sys);
    chk("busy_after_drop", 32'(bus.busy), 0);
    chk("len_err_trunc", 32'(len_err_cnt), 1);
    chk("sb_after_drop", 32'(sb.size()), 0);
    expect_drop = 1'b0;
    @(posedge clk_sys); #1;

    // Reset after two words of a ch0 frame; then both channels request and ch0 must win again.
    w0 = {}; w0.push_back(16'hAAAA); w0.push_back(16'h5555);
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      e.w = '{data: w0[i], sop: (i == 0), eop: 1'b0};
      e.ch = 1'b0;
      sb.push_back(e);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, w0[i], 1'b0);
      for (int t = 0; t < 50; t++) begin @(negedge clk_sys); if (bus.s0_rdy) break; end
      @(posedge clk_sys); #1;
    end
    drive(1'b0, 1'b1, 16'h7777, 1'b0);
    rst_sys = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("mid_reset_outputs", 32'({bus.m_vld, bus.m_sop, bus.m_eop, bus.s0_rdy, bus.s1_rdy,
                                  bus.grant_ch, bus.busy, bus.len_err, bus.m_data}), 0);
    chk("sb_after_reset", 32'(sb.size()), 0);
    @(posedge clk_sys); #1;
    rst_sys = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    w0 = {}; w0.push_back(16'h0000);
    w1 = {}; w1.push_back(16'hFFFF);
    push_frame(1'b0, w0, 16'h1D0F);
    push_frame(1'b1, w1, 16'h0000);
    fork
      send_frame(1'b0, w0);
      send_frame(1'b1, w1);
    join
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
